step_counter: RTL and testbench
===============================

// Module: step_counter
// PURPOSE
//  Parametrised prescaled up/down event counter, successor to the single-direction delay counter.
//  While enabled, a prescaler counts delay_set+1 clock cycles, then steps count by one.
//  The count wraps or saturates at a runtime bound. Sits between input conditioning and display/timer logic.
//  Emits one-cycle step and rollover pulses for downstream sequencing.
// PARAMETERS
//  CNT_W  16  width of count, max_count (and load_val)
//  DLY_W  32  width of delay_set and internal prescaler
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset
//  en         in   1      count enable; low clears prescaler
//  dir        in   1      0 = up, 1 = down
//  sat        in   1      0 = wrap at bounds, 1 = saturate at bounds
//  clear      in   1      synchronous clear of count and prescaler
//  delay_set  in   DLY_W  prescale compare value; step period = delay_set+1 cycles
//  max_count  in   CNT_W  upper bound (inclusive) of count
//  load       in   1      [COUNTER_LOAD_EN only] synchronous parallel load strobe
//  load_val   in   CNT_W  [COUNTER_LOAD_EN only] value loaded on load
//  step       out  1      registered 1-cycle pulse on every step event
//  rollover   out  1      registered 1-cycle pulse when count wraps (either direction)
//  at_bound   out  1      registered; 1 when count==max_count (up) or count==0 (down)
//  count      out  CNT_W  current count
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, prescaler=0, step=0, rollover=0, at_bound recomputed from reset state next edge (=0 after first clk with dir=0, max_count!=0).
//  - Priority per cycle: clear > load (if compiled) > step event > idle.
//  - clear=1: count<=0, prescaler<=0, step<=0, rollover<=0.
//  - en=0: prescaler<=0, step<=0, rollover<=0, count holds.
//  - en=1 and prescaler<delay_set: prescaler<=prescaler+1, step<=0.
//  - en=1 and prescaler>=delay_set: step event -> prescaler<=0, step<=1, count updated:
//    up:   count>=max_count -> sat ? hold : (count<=0, rollover<=1); else count+1.
//    down: count==0 -> sat ? hold : (count<=max_count, rollover<=1);
//          count>max_count -> count<=max_count (no rollover); else count-1.
//  - step pulses even when saturated (count unchanged); rollover never pulses in sat mode.
//  - delay_set=0: step event every enabled cycle; first step on first enabled edge.
//  - First step after en rises lands delay_set+1 edges later (prescaler starts from 0).
//  - max_count=0: up wrap -> count stays 0 with rollover each step; down likewise.
//  - delay_set/max_count/dir/sat may change any cycle; sampled on the edge they are used.
//  - delay_set lowered below current prescaler: next enabled edge is a step event (>= compare).
//  - All arithmetic unsigned, no overflow beyond CNT_W/DLY_W (bounds checked before +/-1).
//  - Reset mid-period aborts prescaler; no pending step survives reset or clear.
// CONFIGURATION
//  COUNTER_LOAD_EN defined: load, load_val ports exist. load=1 (clear=0):
//    count<=min(load_val, max_count), prescaler<=0, step<=0, rollover<=0; overrides step event.
//  COUNTER_LOAD_EN undefined: load/load_val ports absent; logic identical otherwise.
// TESTING
//  1. rst=0 mid-count (count=5) -> outputs 0 immediately, before next clk edge.
//  2. en=1,dir=0,sat=0,delay_set=3,max_count=4 -> step every 4 cycles; count 1,2,3,4,0; rollover with 0.
//  3. dir=1,sat=1,delay_set=0,max_count=9,count=2 -> 1,0,0,0; step each cycle; rollover never.
//  4. en dropped at prescaler=2 (delay_set=5), re-raised -> next step 6 cycles after re-raise.
//  5. count=8, max_count changed to 3: up -> next step count=0 + rollover; down -> count=3, no rollover.
//  6. [COUNTER_LOAD_EN] load=1,load_val=20,max_count=15 same cycle as step event -> count=15, step=0; clear+load -> count=0.

Source files
------------

// File: rtl/step_counter.sv
// step_counter: prescaled up/down event counter with wrap or saturate at a
// runtime bound, emitting registered step / rollover pulses and a bound flag.
// Optional feature: define COUNTER_LOAD_EN to add the load / load_val
// parallel-load ports (load ranks below clear and above a step event).
module step_counter #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clear,
  input  logic [DLY_W-1:0] delay_set,
  input  logic [CNT_W-1:0] max_count,
`ifdef COUNTER_LOAD_EN
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`endif
  output logic             step,
  output logic             rollover,
  output logic             at_bound,
  output logic [CNT_W-1:0] count
);

  logic [DLY_W-1:0] psc, psc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             step_n, roll_n, bound_n;

  // Next-state: clear > load > step event > prescale > idle
  always_comb begin
    cnt_n  = count;
    psc_n  = psc;
    step_n = 1'b0;
    roll_n = 1'b0;
    if (clear) begin
      cnt_n = '0;
      psc_n = '0;
    end
`ifdef COUNTER_LOAD_EN
    else if (load) begin
      cnt_n = (load_val > max_count) ? max_count : load_val;
      psc_n = '0;
    end
`endif
    else if (!en) begin
      psc_n = '0;
    end else if (psc < delay_set) begin
      // psc < delay_set, so the increment cannot overflow DLY_W
      psc_n = psc + 1'b1;
    end else begin
      // >= compare so a lowered delay_set steps on the next enabled edge
      psc_n  = '0;
      step_n = 1'b1;
      if (!dir) begin
        if (count >= max_count) begin
          if (!sat) begin
            cnt_n  = '0;
            roll_n = 1'b1;
          end
        end else begin
          cnt_n = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          if (!sat) begin
            cnt_n  = max_count;
            roll_n = 1'b1;
          end
        end else if (count > max_count) begin
          // bound shrank below the count: snap down without a rollover
          cnt_n = max_count;
        end else begin
          cnt_n = count - 1'b1;
        end
      end
    end
    // flag tracks the count being registered this edge
    bound_n = dir ? (cnt_n == '0) : (cnt_n == max_count);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      psc      <= '0;
      step     <= 1'b0;
      rollover <= 1'b0;
      at_bound <= 1'b0;
    end else begin
      count    <= cnt_n;
      psc      <= psc_n;
      step     <= step_n;
      rollover <= roll_n;
      at_bound <= bound_n;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Directed vector bench for step_counter (default widths).
module tb_step_counter;

  logic        clk = 1'b0;
  logic        rst, en, dir, sat, clear;
  logic [31:0] delay_set;
  logic [15:0] max_count;
  logic        load;
  logic [15:0] load_val;
  logic        step, rollover, at_bound;
  logic [15:0] count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  step_counter #(.CNT_W(16), .DLY_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .clear(clear),
    .delay_set(delay_set), .max_count(max_count),
`ifdef COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .step(step), .rollover(rollover), .at_bound(at_bound), .count(count)
  );

  typedef struct {
    logic        en, dir, sat, clr;
    logic [31:0] ds;
    logic [15:0] mx;
    logic        st, ro, ab;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic e, d, s, c, input logic [31:0] ds,
                              input logic [15:0] mx, input logic st, ro, ab,
                              input logic [15:0] cnt);
    vec_t t;
    t.en = e; t.dir = d; t.sat = s; t.clr = c; t.ds = ds; t.mx = mx;
    t.st = st; t.ro = ro; t.ab = ab; t.cnt = cnt;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic st, ro, ab, input logic [15:0] cnt);
    n_vec++;
    if (step !== st || rollover !== ro || at_bound !== ab || count !== cnt) begin
      n_err++;
      $display("FAIL %s: got step=%b roll=%b bound=%b count=%0d, want step=%b roll=%b bound=%b count=%0d",
               nm, step, rollover, at_bound, count, st, ro, ab, cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b0; sat = 1'b0; clear = 1'b0;
    delay_set = '0; max_count = 16'd4; load = 1'b0; load_val = '0;
    #3;
    chk("reset_state", 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    rst = 1'b1;

    // up wrap, delay 3, bound 4: steps every 4th edge, counts 1,2,3,4,0
    for (int i = 1; i <= 20; i++)
      add(1, 0, 0, 0, 3, 4, (i % 4 == 0), (i == 20), ((i / 4) % 5 == 4), 16'((i / 4) % 5));
    // climb to 2 with delay 0
    add(1, 0, 0, 0, 0, 9, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 9, 1, 0, 0, 2);
    // down saturate: 1,0,0,0 with step every cycle, no rollover
    add(1, 1, 1, 0, 0, 9, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 9, 1, 0, 1, 0);
    add(1, 1, 1, 0, 0, 9, 1, 0, 1, 0);
    add(1, 1, 1, 0, 0, 9, 1, 0, 1, 0);
    // down wrap to bound, then 8
    add(1, 1, 0, 0, 0, 9, 1, 1, 0, 9);
    add(1, 1, 0, 0, 0, 9, 1, 0, 0, 8);
    // count 8, bound drops to 3, up: wrap to 0 with rollover
    add(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 9, 1, 1, 0, 9);
    add(1, 1, 0, 0, 0, 9, 1, 0, 0, 8);
    // count 8, bound drops to 3, down: snap to 3 without rollover
    add(1, 1, 0, 0, 0, 3, 1, 0, 0, 3);
    add(1, 1, 0, 0, 0, 3, 1, 0, 0, 2);
    // disabled: hold
    add(0, 1, 0, 0, 0, 3, 0, 0, 0, 2);
    // clear with en high; bound 0 makes the flag set at count 0
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // bound 0: rollover every step up and down, none when saturating
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    // en dropped at prescaler 2 (delay 5): step 6 edges after re-raise
    add(1, 0, 0, 0, 5, 9, 0, 0, 0, 0);
    add(1, 0, 0, 0, 5, 9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5, 9, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 5, 9, 0, 0, 0, 0);
    add(1, 0, 0, 0, 5, 9, 1, 0, 0, 1);
    // delay lowered below prescaler (3) -> immediate step
    for (int i = 1; i <= 3; i++) add(1, 0, 0, 0, 5, 9, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 9, 1, 0, 0, 2);
    // saturate up at bound 2: step pulses, count holds
    add(1, 0, 1, 0, 0, 2, 1, 0, 1, 2);
    // clear mid-period leaves no pending step
    add(1, 0, 0, 0, 1, 9, 0, 0, 0, 2);
    add(1, 0, 0, 1, 1, 9, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 9, 1, 0, 0, 1);

    foreach (vq[i]) begin
      en = vq[i].en; dir = vq[i].dir; sat = vq[i].sat; clear = vq[i].clr;
      delay_set = vq[i].ds; max_count = vq[i].mx;
      tick();
      chk($sformatf("vec%0d", i), vq[i].st, vq[i].ro, vq[i].ab, vq[i].cnt);
    end

    // async reset mid-count: count at 5, outputs drop before next edge
    en = 1'b1; dir = 1'b0; sat = 1'b0; clear = 1'b0; delay_set = 0; max_count = 9;
    repeat (4) tick();
    chk("pre_reset_count", 1'b1, 1'b0, 1'b0, 16'd5);
    #2 rst = 1'b0;
    #1 chk("async_reset", 1'b0, 1'b0, 1'b0, 16'd0);
    en = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk("post_reset_edge", 1'b0, 1'b0, 1'b0, 16'd0);

`ifdef COUNTER_LOAD_EN
    // load clamps to bound and overrides a due step event
    en = 1'b1; delay_set = 0; max_count = 15; load = 1'b1; load_val = 16'd20;
    tick();
    chk("load_clamp", 1'b0, 1'b0, 1'b1, 16'd15);
    // clear beats load
    clear = 1'b1;
    tick();
    chk("clear_over_load", 1'b0, 1'b0, 1'b0, 16'd0);
    clear = 1'b0; load_val = 16'd7;
    tick();
    chk("load_plain", 1'b0, 1'b0, 1'b0, 16'd7);
    load = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
